// File: rtl/sound_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : sound_scheduler
// Purpose  : Fixed-priority request scheduler that programs the ADPCM sound
//            engine from a sample directory and tracks playback to completion.
// Revision : 1.0
//------------------------------------------------------------------------------
module sound_scheduler #(
   parameter  int NUM_REQ = 4,
   localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_id,
   input  logic                   stop,
   input  logic [7:0]             volume,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   output logic [c_IDX_W-1:0]     cur_req,
   output logic [9:0]             dir_addr,
   input  logic [7:0]             dir_data,
   output logic [3:0]             snd_addr,
   output logic [7:0]             snd_data,
   output logic                   snd_write,
   input  logic [15:0]            snd_rom_addr
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_ARB  = 4'd1,
      S_W0   = 4'd2,
      S_W1   = 4'd3,
      S_W2   = 4'd4,
      S_W3   = 4'd5,
      S_VOL  = 4'd6,
      S_PLAY = 4'd7,
      S_BUSY = 4'd8,
      S_STOP = 4'd9
   } state_t;

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_pend;
   logic [7:0]           r_id [NUM_REQ];
   logic [7:0]           r_cur_id;
   logic [15:0]          r_end;
   logic [7:0]           r_vol;

   logic [NUM_REQ-1:0]   w_pend;
   logic                 w_any;
   logic [c_IDX_W-1:0]   w_win;
   logic [7:0]           w_id_eff [NUM_REQ];
   logic [7:0]           w_win_id;
   logic                 w_done;
   logic                 w_preempt;

   // A request in the current cycle counts as pending so that arbitration
   // happens in the same cycle the pulse is seen.
   always_comb begin
      w_pend = r_pend | req;
      w_any  = |w_pend;
      w_win  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_pend[i]) w_win = c_IDX_W'(i);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         w_id_eff[i] = req[i] ? req_id[8*i +: 8] : r_id[i];
      end
      w_win_id  = w_id_eff[w_win];
      w_done    = (snd_rom_addr == (r_end + 16'd1));
      w_preempt = w_any && (w_win < cur_req);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pend    <= '0;
         r_cur_id  <= '0;
         r_end     <= '0;
         r_vol     <= '0;
         grant     <= '0;
         busy      <= 1'b0;
         cur_req   <= '0;
         dir_addr  <= '0;
         snd_addr  <= '0;
         snd_data  <= '0;
         snd_write <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) r_id[i] <= '0;
      end else begin
         grant     <= '0;
         snd_write <= 1'b0;
         // The grant visible this cycle clears its bit unless re-requested.
         r_pend    <= (r_pend & ~grant) | req;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) r_id[i] <= req_id[8*i +: 8];
         end

         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state  <= S_ARB;
                  cur_req  <= w_win;
                  r_cur_id <= w_win_id;
                  dir_addr <= {w_win_id, 2'd0};
               end
            end
            S_ARB: begin
               r_state   <= S_W0;
               snd_write <= 1'b1;
               snd_addr  <= 4'd0;
               snd_data  <= dir_data;
               dir_addr  <= {r_cur_id, 2'd1};
            end
            S_W0: begin
               r_state   <= S_W1;
               snd_write <= 1'b1;
               snd_addr  <= 4'd1;
               snd_data  <= dir_data;
               dir_addr  <= {r_cur_id, 2'd2};
            end
            S_W1: begin
               r_state    <= S_W2;
               snd_write  <= 1'b1;
               snd_addr   <= 4'd4;
               snd_data   <= dir_data;
               r_end[7:0] <= dir_data;
               dir_addr   <= {r_cur_id, 2'd3};
            end
            S_W2: begin
               r_state     <= S_W3;
               snd_write   <= 1'b1;
               snd_addr    <= 4'd5;
               snd_data    <= dir_data;
               r_end[15:8] <= dir_data;
            end
            S_W3: begin
               r_state   <= S_VOL;
               snd_write <= 1'b1;
               snd_addr  <= 4'd12;
               snd_data  <= volume;
               r_vol     <= volume;
            end
            S_VOL: begin
               r_state   <= S_PLAY;
               snd_write <= 1'b1;
               snd_addr  <= 4'd8;
               snd_data  <= 8'h00;
               busy      <= 1'b1;
               for (int i = 0; i < NUM_REQ; i++) begin
                  grant[i] <= (cur_req == c_IDX_W'(i));
               end
            end
            S_PLAY: begin
               r_state <= S_BUSY;
            end
            S_BUSY: begin
               if (stop) begin
                  // Rewriting the volume register halts the engine.
                  r_state   <= S_STOP;
                  snd_write <= 1'b1;
                  snd_addr  <= 4'd12;
                  snd_data  <= r_vol;
                  busy      <= 1'b0;
               end else if (w_preempt) begin
                  r_state  <= S_ARB;
                  busy     <= 1'b0;
                  cur_req  <= w_win;
                  r_cur_id <= w_win_id;
                  dir_addr <= {w_win_id, 2'd0};
               end else if (w_done) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            S_STOP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/sound_scheduler.md
# sound_scheduler

Request scheduler and sequencer for the Charles ADPCM sound engine. Up to NUM_REQ game-side requesters post 8-bit sample IDs. The block arbitrates them by fixed priority and looks up each sample's start/end address in a sample directory ROM. It then programs the sound engine over its 4-bit register bus (start, end, volume, play) and tracks playback until the engine's ROM address passes the sample end. It sits between the CPU-visible sound port and the sound engine, and replaces direct CPU register writes.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; index 0 is highest priority.

Ports:
- clk  in  1  system clock, same clock as the sound engine.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  one-cycle request pulse per requester.
- req_id  in  8*NUM_REQ  packed sample IDs; requester i uses bits [8i+7:8i], sampled with req[i].
- stop  in  1  one-cycle pulse that aborts the current playback.
- volume  in  8  global volume, sampled in the VOL cycle.
- grant  out  NUM_REQ  one-cycle pulse on the winner's bit, asserted in the PLAY-write cycle.
- busy  out  1  high from the PLAY-write cycle until playback completes or is stopped.
- cur_req  out  2 (clog2 NUM_REQ)  index of the sample currently programmed or playing.
- dir_addr  out  10  sample directory address, {id, byte[1:0]}.
- dir_data  in  8  directory byte; valid the cycle after dir_addr. Byte order: 0 = start lo, 1 = start hi, 2 = end lo, 3 = end hi.
- snd_addr  out  4  sound engine register address.
- snd_data  out  8  sound engine register data.
- snd_write  out  1  sound engine write strobe.
- snd_rom_addr  in  16  sound engine's current sample ROM address, used for done detection.

## Operation
Pending latches:
- req[i] sets pending[i] and captures req_id into id[i].
- A repeat request while pending overwrites id[i].
- A grant clears pending[i]. If req[i] arrives in the same cycle as grant[i], the new request wins: pending stays set with the new ID.

Arbitration:
- The winner is the lowest index with pending set.

States:
- IDLE: when any pending bit is set, go to ARB.
- ARB: latch the winner into cur_req and its ID; drive dir_addr = {id, 2'd0}.
- W0..W3: write directory bytes 0..3 to snd_addr 0, 1, 4, 5 respectively. Advance dir_addr each cycle. Capture the 16-bit end address.
- VOL: write snd_addr 12 with snd_data = volume.
- PLAY: write snd_addr 8 (data 0); pulse grant[cur_req]; set busy; go to BUSY.
- BUSY, exits checked in this priority:
  1. stop: go to STOP.
  2. A pending requester with index < cur_req: preempt, go to ARB. The engine halts on the first new write.
  3. snd_rom_addr == end + 1 (16-bit wrap): done, go to IDLE.
- STOP: write snd_addr 12 with the last volume, which halts the engine. Clear busy; go to IDLE. Pending bits are untouched.

Other rules:
- stop outside BUSY is ignored.
- Equal- or lower-priority requests wait until BUSY exits.
- busy drops in the cycle the block leaves BUSY, including the preemption exit to ARB.
- The directory must not contain end = 16'hFFFF. This value is not supported.

## Timing
- All outputs are registered.
- Reset values: grant = 0, busy = 0, cur_req = 0, dir_addr = 0, snd_addr = 0, snd_data = 0, snd_write = 0. All pending bits clear; state = IDLE.
- Reset mid-sequence returns to IDLE in the next cycle with no further writes. The sound engine is reset independently.
- Programming timeline from idle, with req sampled at cycle t:
  - t+1: ARB.
  - t+2 to t+5: snd_write for addresses 0, 1, 4, 5.
  - t+6: volume write.
  - t+7: play write, grant pulse, busy rises.
- snd_write is high in exactly 6 consecutive cycles per programming sequence and in exactly 1 cycle for STOP. It is never high in IDLE, ARB or BUSY.
- Done-detection latency: busy falls 1 cycle after snd_rom_addr first equals end + 1.
- Preemption: ARB follows the BUSY cycle in which the higher-priority pending bit is seen. The new play write comes 6 cycles after ARB.

## Test plan
- Single request: req[2] with ID 0x05; directory bytes 00 10 FF 10 → writes (0,00) (1,10) (4,FF) (5,10) (12,vol) (8,00) at t+2..t+7; grant = 4'b0100 at t+7; busy falls 1 cycle after snd_rom_addr = 0x1100.
- Simultaneous req[1] and req[3]: requester 1 is granted first. Requester 3 is granted 7 cycles after requester 1's playback completes.
- Preemption: while requester 2 is BUSY, req[0] fires → ARB the next cycle, requester 0's play write 6 cycles after that; pending[2] stays clear.
- Lower priority during playback: req[3] while requester 1 is BUSY → no writes until done, then requester 3 is programmed.
- stop in BUSY → single write (12, last volume) in the next cycle; busy = 0; stop during W1 → ignored, and the sequence completes normally.
- Reset asserted at W2 → snd_write = 0 from the next cycle; all pending bits cleared; outputs at reset values; a new req is served normally.
